// File: rtl/uart_tx.sv
// 8N1 UART transmitter, one byte per valid/ready handshake, registered TX.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx #(
    parameter int BAUD_RATE     = 9600,
    parameter int CLOCK_FREQ_HZ = 12000000
) (
    input  logic       hwclk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       TX
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_data;
    logic            r_tx;

    state_t          w_state_nxt;
    logic [CW-1:0]   w_baud_nxt;
    logic [2:0]      w_bit_nxt;
    logic [7:0]      w_data_nxt;
    logic            w_tx_nxt;
    logic            w_boundary;
    logic            w_ready;
    logic            w_accept;

    assign w_ready    = (r_state == S_IDLE);
    assign w_accept   = tx_valid && w_ready;
    assign w_boundary = (r_baud_cnt == LAST);

    assign tx_ready = w_ready;
    assign busy     = !w_ready;
    assign TX       = r_tx;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_data     <= w_data_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    // Next TX is computed one edge ahead so the pin itself is a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_boundary ? '0 : r_baud_cnt + CW'(1);
        w_bit_nxt   = r_bit_cnt;
        w_data_nxt  = r_data;
        w_tx_nxt    = r_tx;
        unique case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_data_nxt  = tx_data;
                    w_tx_nxt    = 1'b0;
                end
            end
            S_START: begin
                if (w_boundary) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_data[0];
                end
            end
            S_DATA: begin
                if (w_boundary) begin
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = S_PARITY;
                        w_tx_nxt    = ^r_data;
`else
                        w_state_nxt = S_STOP;
                        w_tx_nxt    = 1'b1;
`endif
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                        w_tx_nxt  = r_data[r_bit_cnt + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_boundary) begin
                    w_state_nxt = S_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                w_tx_nxt = 1'b1;
                if (w_boundary) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule
